// File: rtl/rv_dmem_responder.sv
// Data-side memory responder: byte-masked word RAM behind a request/acknowledge
// handshake with a configurable number of wait states before the one-cycle ack.
module rv_dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [3:0]  i_mem_sel,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0]           mem [DEPTH];

    logic                  req_valid;
    logic                  req_err;
    logic                  enter_resp;
    logic                  resp_rd;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  commit_write;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^i_addr[1:0];

    assign req_valid = i_mem_read | i_mem_write;
    assign req_err   = (|i_addr[31:ADDR_WIDTH+2]) | (i_mem_read & i_mem_write);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        err_d      = err_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
        resp_rd    = rd_q;
        resp_err   = err_q;
        rd_addr    = addr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rd_d    = i_mem_read;
                    wr_d    = i_mem_write;
                    err_d   = req_err;
                    addr_d  = i_addr[ADDR_WIDTH+1:2];
                    sel_d   = i_mem_sel;
                    wdata_d = i_wdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: the RAM read uses the live request, not the capture.
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                        resp_rd    = i_mem_read;
                        resp_err   = req_err;
                        rd_addr    = i_addr[ADDR_WIDTH+1:2];
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Error responses clear the read word; plain writes leave it untouched.
        if (enter_resp) begin
            if (resp_err) begin
                rdata_d = 32'h0;
            end else if (resp_rd) begin
                rdata_d = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        addr_q  <= addr_d;
        sel_q   <= sel_d;
        wdata_q <= wdata_d;
    end

    // The write lands on the edge that ends RESP, so a reset there drops it.
    assign commit_write = ~i_reset & (state_q == S_RESP) & wr_q & ~err_q;

    always_ff @(posedge i_clk) begin
        if (commit_write) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign o_ack   = (state_q == S_RESP);
    assign o_err   = o_ack & err_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench for rv_dmem_responder: one instance per WAIT_STATES value 0..7,
// functional cases run on the WAIT_STATES=1 instance.
module tb_rv_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr_a  [8];
    logic [7:0]  rd_v;
    logic [7:0]  wr_v;
    logic [3:0]  sel_a   [8];
    logic [31:0] wdata_a [8];
    logic [7:0]  ack_v;
    logic [7:0]  err_v;
    logic [7:0]  busy_v;
    logic [31:0] rdata_a [8];

    int n_cmp;
    int n_err;
    int last_busy;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        rv_dmem_responder #(
            .ADDR_WIDTH (10),
            .WAIT_STATES(g)
        ) u_dut (
            .i_clk      (clk),
            .i_reset    (rst),
            .i_addr     (addr_a[g]),
            .i_mem_read (rd_v[g]),
            .i_mem_write(wr_v[g]),
            .i_mem_sel  (sel_a[g]),
            .i_wdata    (wdata_a[g]),
            .o_ack      (ack_v[g]),
            .o_err      (err_v[g]),
            .o_rdata    (rdata_a[g]),
            .o_busy     (busy_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int idx);
        int guard;
        guard = 0;
        while (busy_v[idx] !== 1'b0 && guard < 40) begin
            tick();
            guard++;
        end
    endtask

    // Issue one request, hold it until ack, then drop it and check the response.
    task automatic do_req(input int idx, input string tag,
                          input logic [31:0] a, input logic r, input logic w,
                          input logic [3:0] s, input logic [31:0] d,
                          input int exp_lat, input logic exp_err,
                          input logic chk_rd, input logic [31:0] exp_rdata);
        int lat;
        int busy_n;
        wait_idle(idx);
        addr_a[idx]  = a;
        rd_v[idx]    = r;
        wr_v[idx]    = w;
        sel_a[idx]   = s;
        wdata_a[idx] = d;
        lat    = 0;
        busy_n = 0;
        do begin
            tick();
            lat++;
            if (busy_v[idx] === 1'b1) busy_n++;
        end while (ack_v[idx] !== 1'b1 && lat < 40);
        rd_v[idx] = 1'b0;
        wr_v[idx] = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " err"}, {31'h0, err_v[idx]}, {31'h0, exp_err});
        if (chk_rd) chk({tag, " rdata"}, rdata_a[idx], exp_rdata);
        last_busy = busy_n;
    endtask

    initial begin
        int t;
        n_cmp = 0;
        n_err = 0;
        last_busy = 0;
        rst  = 1'b1;
        rd_v = 8'h0;
        wr_v = 8'h0;
        for (int i = 0; i < 8; i++) begin
            addr_a[i]  = 32'h0;
            sel_a[i]   = 4'h0;
            wdata_a[i] = 32'h0;
        end
        tick();
        tick();
        rst = 1'b0;

        chk("reset ack",   {31'h0, ack_v[1]},  32'h0);
        chk("reset err",   {31'h0, err_v[1]},  32'h0);
        chk("reset busy",  {31'h0, busy_v[1]}, 32'h0);
        chk("reset rdata", rdata_a[1],         32'h0);

        do_req(1, "wr full",  32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0);
        chk("wr full busy", 32'(last_busy), 32'd2);
        do_req(1, "rd full",  32'h10, 1'b1, 1'b0, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'hDEADBEEF);

        do_req(1, "wr base",  32'h20, 1'b0, 1'b1, 4'hF, 32'h11223344, 2, 1'b0, 1'b0, 32'h0);
        do_req(1, "wr merge", 32'h20, 1'b0, 1'b1, 4'b0101, 32'hAABBCCDD, 2, 1'b0, 1'b0, 32'h0);
        do_req(1, "rd merge", 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 2, 1'b0, 1'b1, 32'h11BB33DD);

        do_req(1, "wr word0", 32'h0, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 2, 1'b0, 1'b0, 32'h0);
        do_req(1, "rd oor",   32'h00001000, 1'b1, 1'b0, 4'hF, 32'h0, 2, 1'b1, 1'b1, 32'h0);
        do_req(1, "wr oor",   32'h00001000, 1'b0, 1'b1, 4'hF, 32'h55555555, 2, 1'b1, 1'b0, 32'h0);
        do_req(1, "rd word0", 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'hCAFEF00D);
        do_req(1, "rd+wr",    32'h10, 1'b1, 1'b1, 4'hF, 32'h0, 2, 1'b1, 1'b1, 32'h0);

        do_req(1, "wr sel0",  32'h10, 1'b0, 1'b1, 4'h0, 32'h01234567, 2, 1'b0, 1'b0, 32'h0);
        do_req(1, "rd sel0",  32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 2, 1'b0, 1'b1, 32'hDEADBEEF);

        // Reset while the write to 0x4 is waiting.
        do_req(1, "wr prior", 32'h4, 1'b0, 1'b1, 4'hF, 32'h0BADCAFE, 2, 1'b0, 1'b0, 32'h0);
        do_req(1, "rd pre",   32'h10, 1'b1, 1'b0, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'hDEADBEEF);
        wait_idle(1);
        addr_a[1]  = 32'h4;
        wr_v[1]    = 1'b1;
        sel_a[1]   = 4'hF;
        wdata_a[1] = 32'h12345678;
        tick();
        chk("rst wait busy before", {31'h0, busy_v[1]}, 32'h1);
        rst     = 1'b1;
        wr_v[1] = 1'b0;
        tick();
        chk("rst wait ack",   {31'h0, ack_v[1]},  32'h0);
        chk("rst wait busy",  {31'h0, busy_v[1]}, 32'h0);
        chk("rst wait rdata", rdata_a[1],         32'h0);
        rst = 1'b0;
        tick();
        chk("rst wait no late ack", {31'h0, ack_v[1]}, 32'h0);
        do_req(1, "rd after rst", 32'h4, 1'b1, 1'b0, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'h0BADCAFE);

        // Reset coinciding with a request: nothing is captured.
        wait_idle(1);
        rst        = 1'b1;
        addr_a[1]  = 32'h4;
        wr_v[1]    = 1'b1;
        sel_a[1]   = 4'hF;
        wdata_a[1] = 32'hFFFFFFFF;
        tick();
        rst     = 1'b0;
        wr_v[1] = 1'b0;
        chk("rst+req busy", {31'h0, busy_v[1]}, 32'h0);
        tick();
        chk("rst+req no ack", {31'h0, ack_v[1]}, 32'h0);
        do_req(1, "rd rst+req", 32'h4, 1'b1, 1'b0, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'h0BADCAFE);

        // Back-to-back read-after-write at zero wait states.
        do_req(0, "raw wr", 32'h30, 1'b0, 1'b1, 4'hF, 32'h600DF00D, 1, 1'b0, 1'b0, 32'h0);
        do_req(0, "raw rd", 32'h30, 1'b1, 1'b0, 4'hF, 32'h0, 1, 1'b0, 1'b1, 32'h600DF00D);

        for (int n = 0; n < 8; n++) begin
            do_req(n, $sformatf("sweep%0d", n), 32'h0, 1'b1, 1'b0, 4'hF, 32'h0,
                   n + 1, 1'b0, 1'b0, 32'h0);
            chk($sformatf("sweep%0d busy", n), 32'(last_busy), 32'(n + 1));

            // Hold the request through the cycle after ack: it is served again.
            wait_idle(n);
            addr_a[n] = 32'h0;
            rd_v[n]   = 1'b1;
            t = 0;
            do begin
                tick();
                t++;
            end while (ack_v[n] !== 1'b1 && t < 40);
            t = 0;
            do begin
                tick();
                t++;
                if (t == 2) rd_v[n] = 1'b0;
            end while (ack_v[n] !== 1'b1 && t < 40);
            rd_v[n] = 1'b0;
            chk($sformatf("sweep%0d reack gap", n), 32'(t), 32'(n + 2));
        end

        wait_idle(7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_dmem_responder.md
# rv_dmem_responder

Data-side memory responder for the RV core: the slave end of the memory stage's request interface. It accepts a word address, read/write strobes, byte-lane select and lane-aligned write data, performs byte-masked writes into an internal word-organized RAM, returns full 32-bit read words, and signals completion with a one-cycle acknowledge after a configurable number of wait states. It sits between the memory stage and the writeback load-extraction logic. Load sign/zero extension by funct3 and address low bits stays downstream.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2^ADDR_WIDTH words.
- WAIT_STATES, 1, extra cycles inserted before acknowledge; legal range 0..7.

- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_addr  input  32  byte address; i_addr[1:0] is ignored by this block.
- i_mem_read  input  1  read request.
- i_mem_write  input  1  write request.
- i_mem_sel  input  4  byte-lane enables for writes; bit i enables byte i (bits 8i+7:8i).
- i_wdata  input  32  lane-aligned store data.
- o_ack  output  1  one-cycle completion pulse.
- o_err  output  1  error flag, valid only with o_ack.
- o_rdata  output  32  read word, valid with o_ack on reads.
- o_busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, WAIT and RESP.
  - IDLE: if i_mem_read or i_mem_write is high at an edge, capture addr, read, write, sel and wdata into internal registers. Load the wait counter with WAIT_STATES. Go to RESP if WAIT_STATES=0, otherwise go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter equals 1, go to RESP.
  - RESP: assert o_ack for exactly one cycle, then return to IDLE.
- Request inputs are ignored outside IDLE. The requester must hold the request stable until o_ack, and must deassert or change it in the cycle after o_ack; a request still present then is treated as a new request.
- Range check: the request is out of range if captured i_addr[31:ADDR_WIDTH+2] is nonzero. An out-of-range request acks with o_err=1, suppresses the write and returns o_rdata=0.
- Read and write both high is illegal. It acks with o_err=1, with no RAM access and o_rdata=0.
- Writes: on the edge that ends the RESP cycle, RAM[addr[ADDR_WIDTH+1:2]] is updated for each byte whose sel bit is set. sel=4'b0000 is a legal no-op that still acks with o_err=0.
- Reads: the RAM word is registered into o_rdata on the edge entering RESP. o_rdata holds its value until the next read or error response. All four lanes are returned regardless of sel.

## Timing
- Reset values: state=IDLE, o_ack=0, o_err=0, o_rdata=0, o_busy=0, counter=0. RAM contents are not reset.
- Latency: for a request sampled at edge T, o_ack is high during cycle T+WAIT_STATES+1. With WAIT_STATES=0, ack is in the cycle immediately after sampling.
- Throughput: one request per WAIT_STATES+2 cycles, since a back-to-back request is sampled in the IDLE cycle following RESP.
- Read-after-write to the same word, back-to-back, returns the new data, because the write commits before the next sample.
- o_busy is high from the cycle after sampling through the RESP cycle inclusive.
- o_err is 0 whenever o_ack is 0.
- Reset mid-operation, in WAIT or RESP: return to IDLE on that edge. The pending write is discarded and no o_ack is issued. o_rdata is cleared to 0.
- Reset and a request at the same edge: reset wins and the request is not captured.

## Test plan
- Full-word write then read, WAIT_STATES=1:
  - Write 0xDEADBEEF to byte address 0x10 with sel=4'hF: ack two cycles after sampling, o_err=0.
  - Read of 0x10: ack two cycles after sampling with o_rdata=0xDEADBEEF.
- Byte-lane merge: start from word 0x11223344 at 0x20, write 0xAABBCCDD with sel=4'b0101, then read 0x20 -> 0x11BB33DD.
- Error cases, ADDR_WIDTH=10:
  - Read at 0x00001000: ack with o_err=1, o_rdata=0.
  - Write to 0x00001000 followed by a read of 0x0: word 0 is unchanged.
  - Read and write asserted together: o_err=1.
- Latency sweep WAIT_STATES=0..7:
  - Ack in cycle T+N+1, o_busy high for exactly N+1 cycles.
  - A request held one cycle past ack is re-served, giving a second ack N+2 cycles after the first.
- Reset during WAIT of a write of 0x12345678 to 0x4 with sel=4'hF: no ack, o_busy=0 the next cycle, and a subsequent read of 0x4 returns the prior contents.
- Back-to-back read-after-write to the same word at WAIT_STATES=0: the read, sampled two cycles after the write was sampled, returns the new data.
